exmem_stage: RTL and testbench

EXMEM_STAGE -- requirements
Module: exmem_stage

---
 rtl/exmem_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_exmem_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_stage.sv
// EX/MEM pipeline stage: single-cycle ALU plus a 16-iteration shift-add
// multiplier and restoring divider that stall upstream while they run.
// All outputs except StallOut are registered; StallOut is combinational.
module exmem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidIn,
    input  logic [15:0] OP1In,
    input  logic [15:0] OP2In,
    input  logic [15:0] SEImmdIn,
    input  logic [3:0]  ALUOPIn,
    input  logic [15:0] InstructionIn,
    input  logic        flush,
    output logic        StallOut,
    output logic        ValidOut,
    output logic [15:0] ResultOut,
    output logic [15:0] R15Out,
    output logic        R15WriteOut,
    output logic        ZeroOut,
    output logic        DivZeroOut,
    output logic [15:0] InstructionOut,
    output logic [15:0] StoreDataOut
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;

    // Iterative datapath: hi holds product-high / remainder,
    // lo holds multiplier->product-low / dividend->quotient.
    logic [15:0] acc_hi_r;
    logic [15:0] acc_lo_r;
    logic [15:0] opnd_r;
    logic [15:0] instr_hold_r;
    logic [15:0] store_hold_r;

    logic        is_long_s;
    logic        busy_s;
    logic        accept_long_s;
    logic        final_s;
    logic        single_s;
    logic [15:0] alu_result_s;

    logic [16:0] mul_sum_s;
    logic [16:0] div_shift_s;
    logic [15:0] div_diff_s;
    logic        div_ge_s;
    logic [15:0] step_hi_s;
    logic [15:0] step_lo_s;

    // Single-cycle ALU; all arithmetic unsigned and wrapping at 16 bits.
    function automatic logic [15:0] alu_fn(
        input logic [3:0]  op,
        input logic [15:0] a,
        input logic [15:0] b,
        input logic [15:0] imm
    );
        logic [15:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << b[3:0];
            OP_SRL:  r = a >> b[3:0];
            OP_ADDI: r = a + imm;
            default: r = b;
        endcase
        return r;
    endfunction

    // Decode of the current request and of the iteration step results.
    always_comb begin
        is_long_s     = (ALUOPIn == OP_MUL) || (ALUOPIn == OP_DIV);
        busy_s        = (state_r == ST_MUL) || (state_r == ST_DIV);
        accept_long_s = (state_r == ST_IDLE) && ValidIn && is_long_s && !flush;
        single_s      = (state_r == ST_IDLE) && ValidIn && !is_long_s;
        final_s       = busy_s && (cnt_r == 4'd15) && !flush;
        alu_result_s  = alu_fn(ALUOPIn, OP1In, OP2In, SEImmdIn);

        // Shift-add multiply: add multiplicand when the low bit is set,
        // then shift the 33-bit {carry, hi, lo} right by one.
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : 17'd0);

        // Restoring divide: shift the next dividend bit into the remainder
        // and subtract the divisor when it fits. A zero divisor always
        // "fits", which naturally yields quotient FFFF and remainder OP1.
        div_shift_s = {acc_hi_r, acc_lo_r[15]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        div_diff_s  = div_shift_s[15:0] - opnd_r;

        if (state_r == ST_MUL) begin
            step_hi_s = mul_sum_s[16:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[15:1]};
        end else begin
            step_hi_s = div_ge_s ? div_diff_s : div_shift_s[15:0];
            step_lo_s = {acc_lo_r[14:0], div_ge_s};
        end
    end

    // Next-state and stall decode; stall drops on reset, flush and the
    // final iteration so upstream advances as the result registers.
    always_comb begin
        state_nxt_s = state_r;
        StallOut    = 1'b0;
        if (!rst) begin
            state_nxt_s = ST_IDLE;
            StallOut    = 1'b0;
        end else if (flush) begin
            state_nxt_s = ST_IDLE;
            StallOut    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ValidIn && is_long_s) begin
                        state_nxt_s = (ALUOPIn == OP_MUL) ? ST_MUL : ST_DIV;
                        StallOut    = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        StallOut    = 1'b0;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt_r == 4'd15) begin
                        state_nxt_s = ST_IDLE;
                        StallOut    = 1'b0;
                    end else begin
                        state_nxt_s = state_r;
                        StallOut    = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    StallOut    = 1'b0;
                end
            endcase
        end
    end

    // State register and iteration counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            if (flush || !busy_s) begin
                cnt_r <= 4'd0;
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end
    end

    // Operand latch at acceptance and one multiply/divide step per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_hi_r     <= 16'd0;
            acc_lo_r     <= 16'd0;
            opnd_r       <= 16'd0;
            instr_hold_r <= 16'd0;
            store_hold_r <= 16'd0;
        end else if (accept_long_s) begin
            acc_hi_r     <= 16'd0;
            acc_lo_r     <= OP1In;
            opnd_r       <= OP2In;
            instr_hold_r <= InstructionIn;
            store_hold_r <= OP2In;
        end else if (busy_s && !flush) begin
            acc_hi_r <= step_hi_s;
            acc_lo_r <= step_lo_s;
        end else begin
            acc_hi_r <= acc_hi_r;
            acc_lo_r <= acc_lo_r;
        end
    end

    // EX/MEM output register: result, bubble, or flush-cleared flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ValidOut       <= 1'b0;
            R15WriteOut    <= 1'b0;
            DivZeroOut     <= 1'b0;
            ZeroOut        <= 1'b0;
            ResultOut      <= 16'd0;
            R15Out         <= 16'd0;
            InstructionOut <= 16'd0;
            StoreDataOut   <= 16'd0;
        end else if (flush) begin
            ValidOut    <= 1'b0;
            R15WriteOut <= 1'b0;
            DivZeroOut  <= 1'b0;
        end else if (final_s) begin
            ValidOut       <= 1'b1;
            R15WriteOut    <= 1'b1;
            DivZeroOut     <= (state_r == ST_DIV) && (opnd_r == 16'd0);
            ResultOut      <= step_lo_s;
            ZeroOut        <= (step_lo_s == 16'd0);
            R15Out         <= step_hi_s;
            InstructionOut <= instr_hold_r;
            StoreDataOut   <= store_hold_r;
        end else if (single_s) begin
            ValidOut       <= 1'b1;
            R15WriteOut    <= 1'b0;
            DivZeroOut     <= 1'b0;
            ResultOut      <= alu_result_s;
            ZeroOut        <= (alu_result_s == 16'd0);
            InstructionOut <= InstructionIn;
            StoreDataOut   <= OP2In;
        end else begin
            ValidOut    <= 1'b0;
            R15WriteOut <= 1'b0;
            DivZeroOut  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exmem_stage.sv
// Self-checking bench for exmem_stage: directed and random stimulus checked
// against an arithmetic reference model.
module tb_exmem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidIn;
    logic [15:0] OP1In, OP2In, SEImmdIn, InstructionIn;
    logic [3:0]  ALUOPIn;
    logic        flush;
    logic        StallOut, ValidOut, R15WriteOut, ZeroOut, DivZeroOut;
    logic [15:0] ResultOut, R15Out, InstructionOut, StoreDataOut;

    int checks = 0;
    int errors = 0;

    exmem_stage dut (
        .clk(clk), .rst(rst), .ValidIn(ValidIn), .OP1In(OP1In), .OP2In(OP2In),
        .SEImmdIn(SEImmdIn), .ALUOPIn(ALUOPIn), .InstructionIn(InstructionIn),
        .flush(flush), .StallOut(StallOut), .ValidOut(ValidOut),
        .ResultOut(ResultOut), .R15Out(R15Out), .R15WriteOut(R15WriteOut),
        .ZeroOut(ZeroOut), .DivZeroOut(DivZeroOut),
        .InstructionOut(InstructionOut), .StoreDataOut(StoreDataOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ValidIn = 1'b0; flush = 1'b0; ALUOPIn = 4'd0;
        OP1In = 16'd0; OP2In = 16'd0; SEImmdIn = 16'd0; InstructionIn = 16'd0;
    endtask

    // Reference model for single-cycle ops, plain integer arithmetic.
    function automatic logic [15:0] model_single(input logic [3:0] op,
            input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm);
        longint r;
        longint sh;
        sh = longint'(b) % 16;
        case (op)
            4'd0: r = longint'(a) + longint'(b);
            4'd1: r = longint'(a) + 65536 - longint'(b);
            4'd2: r = longint'(a & b);
            4'd3: r = longint'(a | b);
            4'd4: r = longint'(a ^ b);
            4'd5: r = longint'(a) * (longint'(1) << sh);
            4'd6: r = longint'(a) / (longint'(1) << sh);
            4'd7: r = longint'(a) + longint'(imm);
            default: r = longint'(b);
        endcase
        return 16'(r % 65536);
    endfunction

    // One single-cycle op (or a bubble when vin=0): latency 1, no stall.
    task automatic do_single(input logic [3:0] op, input logic [15:0] a,
            input logic [15:0] b, input logic [15:0] imm, input logic vin,
            input string name);
        logic [15:0] er;
        logic [15:0] ins;
        ins = 16'($urandom);
        er  = model_single(op, a, b, imm);
        ValidIn = vin; ALUOPIn = op; OP1In = a; OP2In = b; SEImmdIn = imm;
        InstructionIn = ins; flush = 1'b0;
        #1;
        checks++;
        if (StallOut !== 1'b0) begin
            errors++; $display("FAIL %s stall got %b exp 0", name, StallOut);
        end
        tick();
        checks++;
        if (vin) begin
            if ({ValidOut, R15WriteOut, DivZeroOut, ZeroOut, ResultOut, InstructionOut, StoreDataOut}
                !== {1'b1, 1'b0, 1'b0, (er == 16'd0), er, ins, b}) begin
                errors++;
                $display("FAIL %s op=%h a=%h b=%h got v%b w%b dz%b z%b res=%h ins=%h sd=%h exp res=%h ins=%h sd=%h",
                    name, op, a, b, ValidOut, R15WriteOut, DivZeroOut, ZeroOut, ResultOut,
                    InstructionOut, StoreDataOut, er, ins, b);
            end
        end else begin
            if ({ValidOut, R15WriteOut, DivZeroOut} !== 3'b000) begin
                errors++;
                $display("FAIL %s bubble got v%b w%b dz%b exp 000", name, ValidOut, R15WriteOut, DivZeroOut);
            end
        end
    endtask

    // One MUL/DIV from acceptance to result, scrambling inputs while busy.
    task automatic run_long(input logic [3:0] op, input logic [15:0] a,
            input logic [15:0] b, input string name);
        logic [15:0] er, e15, ins;
        logic        edz, done;
        int          stalls, edges;
        longint      p;
        if (op == 4'd8) begin
            p = longint'(a) * longint'(b);
            er = 16'(p % 65536); e15 = 16'(p / 65536); edz = 1'b0;
        end else if (b == 16'd0) begin
            er = 16'hFFFF; e15 = a; edz = 1'b1;
        end else begin
            er = a / b; e15 = a % b; edz = 1'b0;
        end
        ins = 16'($urandom);
        ValidIn = 1'b1; ALUOPIn = op; OP1In = a; OP2In = b;
        SEImmdIn = 16'($urandom); InstructionIn = ins; flush = 1'b0;
        stalls = 0; edges = 0; done = 1'b0;
        while (!done && edges < 30) begin
            #1;
            if (StallOut === 1'b1) stalls++; else done = 1'b1;
            tick();
            edges++;
            if (!done) begin
                checks++;
                if (ValidOut !== 1'b0) begin
                    errors++; $display("FAIL %s busy bubble edge %0d got %b exp 0", name, edges, ValidOut);
                end
                ValidIn = 1'($urandom); ALUOPIn = 4'($urandom);
                OP1In = 16'($urandom); OP2In = 16'($urandom); InstructionIn = 16'($urandom);
            end
        end
        checks++;
        if (stalls != 16 || edges != 17) begin
            errors++; $display("FAIL %s timing stalls=%0d edges=%0d exp 16/17", name, stalls, edges);
        end
        checks++;
        if ({ValidOut, R15WriteOut, DivZeroOut, ZeroOut, ResultOut, R15Out, InstructionOut, StoreDataOut}
            !== {1'b1, 1'b1, edz, (er == 16'd0), er, e15, ins, b}) begin
            errors++;
            $display("FAIL %s a=%h b=%h got v%b w%b dz%b z%b res=%h r15=%h ins=%h sd=%h exp dz%b res=%h r15=%h ins=%h sd=%h",
                name, a, b, ValidOut, R15WriteOut, DivZeroOut, ZeroOut, ResultOut, R15Out,
                InstructionOut, StoreDataOut, edz, er, e15, ins, b);
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b0; ValidIn = 1'b1; ALUOPIn = 4'd8; OP1In = 16'h1234; OP2In = 16'h5678;
        SEImmdIn = 16'h1; InstructionIn = 16'hBEEF; flush = 1'b1;
        #1;
        checks++;
        if (StallOut !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b exp 0", StallOut);
        end
        tick(); tick();
        checks++;
        if ({ValidOut, R15WriteOut, DivZeroOut, ZeroOut, ResultOut, R15Out, InstructionOut, StoreDataOut} !== 68'd0) begin
            errors++;
            $display("FAIL reset_outputs got v%b w%b dz%b z%b res=%h r15=%h ins=%h sd=%h exp all 0",
                ValidOut, R15WriteOut, DivZeroOut, ZeroOut, ResultOut, R15Out, InstructionOut, StoreDataOut);
        end
        idle_inputs();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_cycle();
        logic [3:0] op;
        do_single(4'd0, 16'hFFFF, 16'h0002, 16'h0000, 1'b1, "add_wrap");
        do_single(4'd1, 16'h0007, 16'h0007, 16'h0000, 1'b1, "sub_zero");
        do_single(4'd7, 16'hFFF0, 16'h0000, 16'h0011, 1'b1, "addi_wrap");
        do_single(4'd5, 16'h8001, 16'h0013, 16'h0000, 1'b1, "sll_mask");
        do_single(4'd15, 16'h1111, 16'hABCD, 16'h0000, 1'b1, "pass_op2");
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 13));
            if (op >= 4'd8) op = op + 4'd2;
            do_single(op, 16'($urandom), 16'($urandom), 16'($urandom),
                      1'($urandom_range(0, 4) != 0), "rand_single");
        end
        do_single(4'd8, 16'h0003, 16'h0004, 16'h0000, 1'b0, "idle_bubble_mul");
    endtask

    task automatic test_muldiv();
        logic [15:0] b;
        run_long(4'd8, 16'h1234, 16'h0100, "mul_1234x0100");
        run_long(4'd9, 16'd100, 16'd7, "div_100_7");
        run_long(4'd9, 16'd5, 16'd0, "div_by_zero");
        run_long(4'd8, 16'hFFFF, 16'hFFFF, "mul_max");
        run_long(4'd8, 16'h0000, 16'h1234, "mul_zero");
        for (int i = 0; i < 6; i++) begin
            run_long(4'd8, 16'($urandom), 16'($urandom), "rand_mul");
            b = (i == 3) ? 16'd0 : 16'($urandom_range(0, 300));
            run_long(4'd9, 16'($urandom), b, "rand_div");
        end
    endtask

    task automatic test_flush();
        // flush mid-multiply at iteration 8
        ValidIn = 1'b1; ALUOPIn = 4'd8; OP1In = 16'h00FF; OP2In = 16'h0F0F; InstructionIn = 16'h1;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        #1;
        checks++;
        if (StallOut !== 1'b0) begin
            errors++; $display("FAIL flush_mid_stall got %b exp 0", StallOut);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if ({ValidOut, R15WriteOut, DivZeroOut, StallOut} !== 4'b0000) begin
            errors++; $display("FAIL flush_mid_out got v%b w%b dz%b st%b exp 0000",
                ValidOut, R15WriteOut, DivZeroOut, StallOut);
        end
        do_single(4'd0, 16'd20, 16'd22, 16'd0, 1'b1, "add_after_flush");
        // flush on the final divide iteration beats completion
        ValidIn = 1'b1; ALUOPIn = 4'd9; OP1In = 16'd0; OP2In = 16'd0; InstructionIn = 16'h2;
        for (int i = 0; i < 16; i++) tick();
        flush = 1'b1;
        tick();
        idle_inputs();
        #1;
        checks++;
        if ({ValidOut, R15WriteOut, DivZeroOut, StallOut} !== 4'b0000) begin
            errors++; $display("FAIL flush_final_out got v%b w%b dz%b st%b exp 0000",
                ValidOut, R15WriteOut, DivZeroOut, StallOut);
        end
        // flush beats acceptance in IDLE
        ValidIn = 1'b1; ALUOPIn = 4'd9; OP1In = 16'd9; OP2In = 16'd3; flush = 1'b1;
        #1;
        checks++;
        if (StallOut !== 1'b0) begin
            errors++; $display("FAIL flush_accept_stall got %b exp 0", StallOut);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if ({ValidOut, StallOut} !== 2'b00) begin
            errors++; $display("FAIL flush_accept_out got v%b st%b exp 00", ValidOut, StallOut);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        ValidIn = 1'b1; ALUOPIn = 4'd9; OP1In = 16'd1000; OP2In = 16'd9; InstructionIn = 16'h77;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b0;
        #1;
        checks++;
        if (StallOut !== 1'b0) begin
            errors++; $display("FAIL rst_mid_stall got %b exp 0", StallOut);
        end
        tick();
        checks++;
        if ({ValidOut, R15WriteOut, DivZeroOut, ZeroOut, ResultOut, R15Out, InstructionOut, StoreDataOut} !== 68'd0) begin
            errors++; $display("FAIL rst_mid_outputs got v%b res=%h r15=%h ins=%h sd=%h exp all 0",
                ValidOut, ResultOut, R15Out, InstructionOut, StoreDataOut);
        end
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({ValidOut, R15WriteOut, StallOut} !== 3'b000) begin
                errors++; $display("FAIL rst_mid_no_result cycle %0d got v%b w%b st%b exp 000",
                    i, ValidOut, R15WriteOut, StallOut);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_long(4'd8, 16'h1234, 16'h0100, "b2b_mul");
        do_single(4'd1, 16'd3, 16'd5, 16'd0, 1'b1, "b2b_sub");
        #1;
        checks++;
        if (StallOut !== 1'b0) begin
            errors++; $display("FAIL b2b_no_dup_stall got %b exp 0", StallOut);
        end
        ValidIn = 1'b0;
        tick();
        checks++;
        if ({ValidOut, R15WriteOut} !== 2'b00) begin
            errors++; $display("FAIL b2b_no_dup_valid got v%b w%b exp 00", ValidOut, R15WriteOut);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_flush();
        test_reset_mid_div();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
